// File: rtl/mem_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | mem_arbiter_pkg: shared state and port-index types for the arbiter    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SERVE0 = 2'd1,
    S_SERVE1 = 2'd2
  } mem_arb_state_t;

  typedef logic port_idx_t;

endpackage

`default_nettype wire

// File: rtl/mem_pkg.sv
// +----------------------------------------------------------------------+
// | mem_pkg: memory access size and exception mask types                  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {
    MEM_ACCESS_BYTE = 2'd0,
    MEM_ACCESS_HALF = 2'd1,
    MEM_ACCESS_WORD = 2'd2
  } mem_access_t;

  localparam int MEM_EXC_W = 4;

  // One bit per fault class: misaligned, access fault, page fault, reserved
  typedef logic [MEM_EXC_W-1:0] mem_exception_mask_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_rr_pick.sv
// +----------------------------------------------------------------------+
// | mem_arb_rr_pick: two-way round-robin chooser (combinational)          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_arb_rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic      req0_i,
  input  logic      req1_i,
  input  port_idx_t last_grant_i,
  output logic      valid_o,
  output port_idx_t winner_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
    if (req0_i && req1_i) begin
      winner_o = ~last_grant_i;
    end else begin
      winner_o = req1_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_port_arbiter: round-robin sharing of one memory port by 2 masters |
// | Optional counters: define MEM_PORT_ARBITER_STATS_EN.  Rev 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
  import mem_pkg::*;
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                req1,
  input  logic                lock0,
  input  logic                lock1,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   wr_data0,
  input  logic [DATA_W-1:0]   wr_data1,
  input  logic                wr_ena0,
  input  logic                wr_ena1,
  input  mem_access_t         access0,
  input  mem_access_t         access1,
  output logic                gnt0,
  output logic                gnt1,
  output logic [DATA_W-1:0]   rd_data0,
  output logic [DATA_W-1:0]   rd_data1,
  output mem_exception_mask_t exc0,
  output mem_exception_mask_t exc1,
  output logic                rvalid0,
  output logic                rvalid1,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wr_data,
  output logic                mem_wr_ena,
  output mem_access_t         mem_access,
  input  logic [DATA_W-1:0]   mem_rd_data,
  input  mem_exception_mask_t mem_exception
`ifdef MEM_PORT_ARBITER_STATS_EN
  ,
  output logic [31:0]         grants0,
  output logic [31:0]         grants1,
  output logic [31:0]         conflict_cycles
`endif
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);

  mem_arb_state_t      state_q, state_d;
  port_idx_t           last_grant_q, last_grant_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;

  logic                rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0]   rd_data0_q, rd_data1_q;
  mem_exception_mask_t exc0_q, exc1_q;

  logic                pick_valid;
  port_idx_t           pick_port;

  logic                sel1;
  logic                sel_req, sel_lock, sel_wr_ena;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wr_data;
  mem_access_t         sel_access;

  mem_arb_rr_pick u_pick (
    .req0_i       (req0),
    .req1_i       (req1),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid),
    .winner_o     (pick_port)
  );

  // Payload of the port owning the current serve state
  assign sel1        = (state_q == S_SERVE1);
  assign sel_req     = sel1 ? req1     : req0;
  assign sel_lock    = sel1 ? lock1    : lock0;
  assign sel_addr    = sel1 ? addr1    : addr0;
  assign sel_wr_data = sel1 ? wr_data1 : wr_data0;
  assign sel_wr_ena  = sel1 ? wr_ena1  : wr_ena0;
  assign sel_access  = sel1 ? access1  : access0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    mem_addr     = '0;
    mem_wr_data  = '0;
    mem_wr_ena   = 1'b0;
    mem_access   = MEM_ACCESS_WORD;
    case (state_q)
      S_IDLE: begin
        beat_cnt_d = '0;
        if (pick_valid) begin
          state_d = pick_port ? S_SERVE1 : S_SERVE0;
        end
      end
      S_SERVE0, S_SERVE1: begin
        // A request withdrawn before its grant produces no memory cycle
        if (sel_req) begin
          gnt0         = ~sel1;
          gnt1         = sel1;
          mem_addr     = sel_addr;
          mem_wr_data  = sel_wr_data;
          mem_wr_ena   = sel_wr_ena;
          mem_access   = sel_access;
          last_grant_d = sel1;
        end
        if (sel_req && sel_lock && (beat_cnt_q < BEAT_LAST)) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end else begin
          state_d    = S_IDLE;
          beat_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rd_data0_q <= '0;
      rd_data1_q <= '0;
      exc0_q     <= '0;
      exc1_q     <= '0;
    end else begin
      rvalid0_q <= gnt0;
      rvalid1_q <= gnt1;
      if (gnt0) begin
        rd_data0_q <= mem_wr_ena ? '0 : mem_rd_data;
        exc0_q     <= mem_exception;
      end
      if (gnt1) begin
        rd_data1_q <= mem_wr_ena ? '0 : mem_rd_data;
        exc1_q     <= mem_exception;
      end
    end
  end

  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rd_data0 = rd_data0_q;
  assign rd_data1 = rd_data1_q;
  assign exc0     = exc0_q;
  assign exc1     = exc1_q;

`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [31:0] grants0_q, grants1_q, conflict_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      grants0_q  <= '0;
      grants1_q  <= '0;
      conflict_q <= '0;
    end else begin
      if (gnt0) grants0_q <= grants0_q + 32'd1;
      if (gnt1) grants1_q <= grants1_q + 32'd1;
      if ((state_q == S_IDLE) && req0 && req1) conflict_q <= conflict_q + 32'd1;
    end
  end

  assign grants0         = grants0_q;
  assign grants1         = grants1_q;
  assign conflict_cycles = conflict_q;
`endif

endmodule

`default_nettype wire
